shape_sfr_sequencer: RTL and testbench
======================================

# shape_sfr_sequencer

Shares the shape processor's single SFR write/read port among `NUM_REQ` independent requesters. Each request carries a (shape, operation) pair. The sequencer grants requests round-robin and drives one write followed by one read-back. It compares the read-back against the expected resolved value and returns an accepted/rejected response tagged with the requester index. It sits between the configuration masters and the shape processor, and also keeps saturating accept/reject statistics.

## Interface
- `NUM_REQ`, default 4 (legal range 2-8): number of requesters.
- `CNT_W`, default 16: width of the statistics counters.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`  per-requester command valid; must be held until `req_ready`.
- `req_ready`  out  `NUM_REQ`  one-hot single-cycle grant/accept pulse.
- `req_shape`  in  `2*NUM_REQ`  requested shape, requester i in bits [2i+1:2i]; `2'b11` = keep current.
- `req_op`  in  `5*NUM_REQ`  requested operation, requester i in bits [5i+4:5i]; `5'b11111` = keep current.
- `rsp_valid`  out  1  response valid; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  `$clog2(NUM_REQ)`  index of the requester this response belongs to.
- `rsp_accepted`  out  1  1 = read-back matches expected value.
- `rsp_shape`  out  2  read-back shape.
- `rsp_op`  out  5  read-back operation.
- `sp_write`  out  1  shape processor write strobe.
- `sp_write_data`  out  32  shape in [17:16], operation in [4:0], all other bits 0.
- `sp_read`  out  1  shape processor read strobe.
- `sp_read_data`  in  32  valid the cycle after `sp_read`; same field positions as the write data.
- `accept_cnt`  out  `CNT_W`  saturating count of accepted responses.
- `reject_cnt`  out  `CNT_W`  saturating count of rejected responses.

## Operation
- FSM states and transitions:
  - IDLE → WRITE on grant.
  - WRITE → READ.
  - READ → CAPTURE.
  - CAPTURE → RESP.
  - RESP → IDLE when `rsp_valid && rsp_ready`.
- **Arbitration (IDLE only):**
  - Round-robin. Search starts at (last granted + 1) mod `NUM_REQ`.
  - The pointer resets to `NUM_REQ-1`, so requester 0 wins first.
  - On grant, pulse `req_ready[i]` and register the shape, operation and id.
  - No grant is issued outside IDLE.
- **WRITE:** `sp_write`=1 with the registered fields. Keep codes are passed through unchanged.
- **READ:** `sp_read`=1.
- **CAPTURE:** sample `sp_read_data[17:16]` and `[4:0]` into `rsp_shape` and `rsp_op`.
- **Shadow register:**
  - Holds the last captured value. Reset value is shape `01`, operation `00000`, matching the shape processor's reset.
  - Updated in every CAPTURE state.
- **Expected value:** per field, the requested value, or the shadow value if that field carries its keep code.
- **`rsp_accepted`:** 1 iff the captured shape and operation both equal the expected value.
  - Illegal requests are therefore rejected: non-one-hot shape, operation outside {00000, 00001, 01000, 10000, 10001}, or operation[4:3]≠0 with operation[4:3]≠shape.
- **Counters:**
  - Increment once in CAPTURE, selected by the comparison result.
  - Saturate at all-ones; no wrap.
- Only one transaction is in flight at a time. `sp_write` and `sp_read` are never asserted together.

## Timing
- **Reset values:**
  - `req_ready`, `rsp_valid`, `sp_write`, `sp_read`, `rsp_accepted`: 0.
  - `rsp_id`, `rsp_shape`, `rsp_op`, `sp_write_data`, both counters: 0.
  - FSM: IDLE.
- All outputs are registered.
- **Transaction latency, with grant at cycle t:**
  - `req_ready` is high in cycle t.
  - `sp_write` in t+1.
  - `sp_read` in t+2.
  - Capture at the end of t+3.
  - `rsp_valid` high from t+4.
- If `rsp_ready` is high at t+4, the next grant can occur at t+5. Sustained throughput is 1 request per 5 cycles.
- **Back-pressure:** `rsp_valid` and all `rsp_*` fields stay stable while `rsp_ready`=0.
- A requester that drops `req_valid` before being granted is simply skipped. This is a protocol violation, but it causes no hang.
- **Reset mid-transaction:** immediately return to IDLE with the reset values above. The shadow returns to `01`/`00000`, in step with the shape processor's own reset.

## Test plan
- Requester 0 sends shape `01`, op `00001` → `sp_write_data`=`0x0001_0001` at t+1; response id 0, accepted=1, shape `01`, op `00001` at t+4; `accept_cnt`=1.
- Requester 2 sends shape `10`, op `01000` (combination illegal) → read-back `01`/`00000` after reset; accepted=0; `reject_cnt`=1; shadow unchanged.
- All 4 requesters hold `req_valid` → grants in order 0,1,2,3,0 at 5-cycle spacing with `rsp_ready` tied high.
- Requester 1 sends shape `11` (keep), op `10001`, with shadow shape `10` → expected `10`/`10001`, accepted=1.
- Hold `rsp_ready`=0 for 10 cycles → `rsp_*` stable, no new `sp_write` and no `req_ready` pulse until the handshake completes.
- Assert `rst_n`=0 in the READ state → all outputs go to 0 in the same cycle; after release, the first grant goes to requester 0 and the shadow is `01`/`00000`.

Source files
------------

// File: rtl/shape_sfr_sequencer.sv
// Round-robin sequencer sharing one shape-processor SFR port among NUM_REQ requesters.
// Latency: req_ready at t, sp_write t+1, sp_read t+2, capture end of t+3, rsp_valid from t+4.
// Backpressure: response held stable while rsp_ready=0; no new grant until the handshake.
module shape_sfr_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_shape,
  input  logic [5*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_accepted,
  output logic [1:0]           rsp_shape,
  output logic [4:0]           rsp_op,
  output logic                 sp_write,
  output logic [31:0]          sp_write_data,
  output logic                 sp_read,
  input  logic [31:0]          sp_read_data,
  output logic [CNT_W-1:0]     accept_cnt,
  output logic [CNT_W-1:0]     reject_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;

  state_t state, state_nx;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [1:0]         cur_shape;
  logic [4:0]         cur_op;
  logic [1:0]         shadow_shape;
  logic [4:0]         shadow_op;

  logic               arb_vld;
  logic [ID_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic               arb_en;
  logic               grant;
  logic               rsp_hs;
  int                 cand;

  logic [1:0]         cap_shape;
  logic [4:0]         cap_op;
  logic [1:0]         exp_shape;
  logic [4:0]         exp_op;
  logic               cap_match;
  logic [31:0]        wr_word;
  logic               unused_rd_bits;

  assign rsp_hs    = rsp_valid && rsp_ready;
  // Arbitrate while idle with no grant outstanding, or in the cycle the response retires,
  // so that the registered req_ready pulse lands in the first IDLE cycle.
  assign arb_en    = ((state == IDLE) && !(|req_ready)) || ((state == RESP) && rsp_hs);
  assign grant     = arb_en && arb_vld;

  assign cap_shape = sp_read_data[17:16];
  assign cap_op    = sp_read_data[4:0];
  assign exp_shape = (cur_shape == 2'b11)   ? shadow_shape : cur_shape;
  assign exp_op    = (cur_op == 5'b11111)   ? shadow_op    : cur_op;
  assign cap_match = (cap_shape == exp_shape) && (cap_op == exp_op);
  assign wr_word   = {14'b0, cur_shape, 11'b0, cur_op};

  assign unused_rd_bits = ^{sp_read_data[31:18], sp_read_data[15:5]};

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    arb_vld    = 1'b0;
    arb_idx    = '0;
    arb_onehot = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!arb_vld && req_valid[cand]) begin
        arb_vld = 1'b1;
        arb_idx = ID_W'(cand);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_onehot[k] = arb_vld && (int'(arb_idx) == k);
    end
  end

  // Next-state logic for the one-transaction-at-a-time sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_ready) state_nx = WRITE;
      WRITE:   state_nx = READ;
      READ:    state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Grant pulse, request latch and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      cur_id    <= '0;
      cur_shape <= '0;
      cur_op    <= '0;
    end else begin
      req_ready <= grant ? arb_onehot : '0;
      if (grant) begin
        rr_ptr    <= arb_idx;
        cur_id    <= arb_idx;
        cur_shape <= req_shape[2*arb_idx +: 2];
        cur_op    <= req_op[5*arb_idx +: 5];
      end
    end
  end

  // Shape-processor strobes, registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_write      <= 1'b0;
      sp_write_data <= '0;
      sp_read       <= 1'b0;
      rsp_valid     <= 1'b0;
    end else begin
      sp_write      <= (state_nx == WRITE);
      sp_write_data <= (state_nx == WRITE) ? wr_word : '0;
      sp_read       <= (state_nx == READ);
      rsp_valid     <= (state_nx == RESP);
    end
  end

  // Capture read-back, judge it against the expected value, track shadow and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id       <= '0;
      rsp_accepted <= 1'b0;
      rsp_shape    <= '0;
      rsp_op       <= '0;
      shadow_shape <= 2'b01;
      shadow_op    <= 5'b00000;
      accept_cnt   <= '0;
      reject_cnt   <= '0;
    end else if (state == CAPTURE) begin
      rsp_id       <= cur_id;
      rsp_accepted <= cap_match;
      rsp_shape    <= cap_shape;
      rsp_op       <= cap_op;
      shadow_shape <= cap_shape;
      shadow_op    <= cap_op;
      if (cap_match) begin
        if (accept_cnt != {CNT_W{1'b1}}) accept_cnt <= accept_cnt + 1'b1;
      end else begin
        if (reject_cnt != {CNT_W{1'b1}}) reject_cnt <= reject_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shape_sfr_sequencer.sv
// Randomized bench for shape_sfr_sequencer with a shape-processor model and a
// transaction-level reference (legality rules, round-robin order, saturating counts).
// Small counter width is used so saturation is reached during the run.
module tb_shape_sfr_sequencer;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_shape;
  logic [5*N-1:0]  req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic            rsp_accepted;
  logic [1:0]      rsp_shape;
  logic [4:0]      rsp_op;
  logic            sp_write;
  logic [31:0]     sp_write_data;
  logic            sp_read;
  logic [31:0]     sp_read_data;
  logic [CW-1:0]   accept_cnt;
  logic [CW-1:0]   reject_cnt;

  always #5 clk = ~clk;

  shape_sfr_sequencer #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_shape(req_shape), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_accepted(rsp_accepted),
    .rsp_shape(rsp_shape), .rsp_op(rsp_op),
    .sp_write(sp_write), .sp_write_data(sp_write_data),
    .sp_read(sp_read), .sp_read_data(sp_read_data),
    .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [1:0] s, input logic [4:0] o);
    bit op_ok;
    op_ok = (o == 5'b00000) || (o == 5'b00001) || (o == 5'b01000) ||
            (o == 5'b10000) || (o == 5'b10001);
    return ((s == 2'b01) || (s == 2'b10)) && op_ok && ((o[4:3] == 2'b00) || (o[4:3] == s));
  endfunction

  function automatic logic [1:0] keep_s(input logic [1:0] req, input logic [1:0] cur);
    return (req == 2'b11) ? cur : req;
  endfunction

  function automatic logic [4:0] keep_o(input logic [4:0] req, input logic [4:0] cur);
    return (req == 5'b11111) ? cur : req;
  endfunction

  // Shape processor: applies legal writes (keep codes resolved), returns the register on read.
  logic [1:0] pr_shape;
  logic [4:0] pr_op;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_shape     <= 2'b01;
      pr_op        <= 5'b00000;
      sp_read_data <= 32'h0;
    end else begin
      if (sp_write && legal(keep_s(sp_write_data[17:16], pr_shape), keep_o(sp_write_data[4:0], pr_op))) begin
        pr_shape <= keep_s(sp_write_data[17:16], pr_shape);
        pr_op    <= keep_o(sp_write_data[4:0], pr_op);
      end
      if (sp_read) sp_read_data <= {14'b0, pr_shape, 11'b0, pr_op};
    end
  end

  // Reference model state: one transaction tracked by its age since the grant cycle.
  bit         busy;
  int         age;
  int         ptr;
  int         cur_id;
  logic [1:0] cur_sh;
  logic [4:0] cur_op;
  bit         exp_acc;
  logic [1:0] ref_shape;
  logic [4:0] ref_op;
  int         acc_n;
  int         rej_n;
  int         stall;

  task automatic model_reset();
    busy = 0; age = 0; ptr = N - 1; cur_id = 0; cur_sh = 0; cur_op = 0; exp_acc = 0;
    ref_shape = 2'b01; ref_op = 5'b00000; acc_n = 0; rej_n = 0;
  endtask

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic model_step();
    bit arb;
    int w;
    logic [1:0] rs;
    logic [4:0] ro;
    w = -1;
    arb = !busy || (age >= 4 && rsp_ready);
    if (busy && age >= 4 && rsp_ready) busy = 0;
    else if (busy) age++;
    if (arb && req_valid != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      end
      busy = 1; age = 0; ptr = w; cur_id = w;
      cur_sh = req_shape[2*w +: 2];
      cur_op = req_op[5*w +: 5];
      rs = keep_s(cur_sh, ref_shape);
      ro = keep_o(cur_op, ref_op);
      exp_acc = legal(rs, ro);
      if (exp_acc) begin
        ref_shape = rs; ref_op = ro;
        if (acc_n < (1 << CW) - 1) acc_n++;
      end else begin
        if (rej_n < (1 << CW) - 1) rej_n++;
      end
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    exp_rdy = (busy && age == 0) ? N'(1 << cur_id) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("sp_write", 32'(sp_write), 32'(busy && age == 1));
    if (busy && age == 1) chk("sp_write_data", sp_write_data, {14'b0, cur_sh, 11'b0, cur_op});
    chk("sp_read", 32'(sp_read), 32'(busy && age == 2));
    chk("rsp_valid", 32'(rsp_valid), 32'(busy && age >= 4));
    if (busy && age >= 4) begin
      chk("rsp_id", 32'(rsp_id), 32'(cur_id));
      chk("rsp_accepted", 32'(rsp_accepted), 32'(exp_acc));
      chk("rsp_shape", 32'(rsp_shape), 32'(ref_shape));
      chk("rsp_op", 32'(rsp_op), 32'(ref_op));
      chk("accept_cnt", 32'(accept_cnt), 32'(acc_n));
      chk("reject_cnt", 32'(reject_cnt), 32'(rej_n));
    end
  endtask

  function automatic logic [4:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b01000;
      3: return 5'b10000;
      4: return 5'b10001;
      5: return 5'b11111;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        req_valid[i] = 1'b0;
      end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_shape[2*i +: 2] = 2'($urandom_range(0, 3));
        req_op[5*i +: 5] = rand_op();
      end
    end
    if (stall > 0) begin
      stall--;
      rsp_ready = 1'b0;
    end else begin
      if ($urandom_range(0, 39) == 0) stall = 10;
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_sp_write"}, 32'(sp_write), 32'h0);
    chk({tag, "_sp_read"}, 32'(sp_read), 32'h0);
    chk({tag, "_rsp_accepted"}, 32'(rsp_accepted), 32'h0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
    chk({tag, "_rsp_shape"}, 32'(rsp_shape), 32'h0);
    chk({tag, "_rsp_op"}, 32'(rsp_op), 32'h0);
    chk({tag, "_sp_write_data"}, sp_write_data, 32'h0);
    chk({tag, "_accept_cnt"}, 32'(accept_cnt), 32'h0);
    chk({tag, "_reject_cnt"}, 32'(reject_cnt), 32'h0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; req_valid = '0; req_shape = '0; req_op = '0; rsp_ready = 1'b0; stall = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Random traffic phase.
    for (int c = 0; c < 3000; c++) begin
      drive();
      model_step();
      @(negedge clk);
      check_cycle();
    end

    // Run until the transaction is in its read cycle, then reset mid-flight.
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      drive();
      model_step();
      @(negedge clk);
      check_cycle();
      if (busy && age == 2) found = 1;
    end
    chk("reach_read_state", 32'(found), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    stall = 0;
    // Every requester pending; requester 0 asks to keep both fields, exposing the reset shadow.
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_shape[2*i +: 2] = 2'($urandom_range(0, 3));
      req_op[5*i +: 5] = rand_op();
    end
    req_shape[1:0] = 2'b11;
    req_op[4:0] = 5'b11111;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 600; c++) begin
      if (c == 0) begin
        rsp_ready = 1'b1;
        model_step();
      end else begin
        drive();
        model_step();
      end
      @(negedge clk);
      check_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
